// File: rtl/io_regfile_if.sv
// Register-file bus: one write port and two combinational read ports.
// master drives addresses and write data, slave returns read data.
interface io_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              ctrl_writeEnable;
    logic [ADDR_W-1:0] ctrl_writeReg;
    logic [DATA_W-1:0] data_writeReg;
    logic [ADDR_W-1:0] ctrl_readRegA;
    logic [ADDR_W-1:0] ctrl_readRegB;
    logic [DATA_W-1:0] data_readRegA;
    logic [DATA_W-1:0] data_readRegB;

    modport master (
        output ctrl_writeEnable,
        output ctrl_writeReg,
        output data_writeReg,
        output ctrl_readRegA,
        output ctrl_readRegB,
        input  data_readRegA,
        input  data_readRegB
    );

    modport slave (
        input  ctrl_writeEnable,
        input  ctrl_writeReg,
        input  data_writeReg,
        input  ctrl_readRegA,
        input  ctrl_readRegB,
        output data_readRegA,
        output data_readRegB
    );
endinterface

// File: rtl/io_regfile.sv
// Register file with debounced button status registers and exported registers.
// Define IO_REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module io_regfile #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int N_BTN        = 4,
    parameter int BTN_BASE     = 1,
    parameter int N_OUT        = 4,
    parameter int OUT_BASE     = 11,
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic                    clock,
    input  logic                    ctrl_reset_n,
    io_regfile_if.slave             bus,
    input  logic                    io_mode,
    input  logic [N_BTN-1:0]        btn_in,
    output logic [N_BTN-1:0]        btn_event,
    output logic [N_OUT*DATA_W-1:0] io_out
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    localparam bit BAD_BTN = (BTN_BASE < 1) || (BTN_BASE + N_BTN > DEPTH);
    localparam bit BAD_OUT = (OUT_BASE < 1) || (OUT_BASE + N_OUT > DEPTH);
    localparam bit OVERLAP = (BTN_BASE < OUT_BASE + N_OUT) &&
                             (OUT_BASE < BTN_BASE + N_BTN);

    if (BAD_BTN || BAD_OUT || OVERLAP || DEBOUNCE_CYC < 1) begin : g_bad_map
        $error("io_regfile: illegal address map or debounce length");
    end

    logic [DATA_W-1:0] regs [DEPTH];

    logic [N_BTN-1:0] sync_q1;
    logic [N_BTN-1:0] sync_q2;
    logic [N_BTN-1:0] stable;
    logic [N_BTN-1:0] sticky;
    logic [CNT_W-1:0] cnt [N_BTN];

    logic [N_BTN-1:0] settle;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] wr_hit;
    logic [N_BTN-1:0] rd_hit_a;
    logic [N_BTN-1:0] rd_hit_b;
    logic [N_BTN-1:0] sticky_clr;
    logic             wr_any;
    logic             wr_store;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    always_comb begin
        settle     = '0;
        rise       = '0;
        wr_hit     = '0;
        rd_hit_a   = '0;
        rd_hit_b   = '0;
        for (int i = 0; i < N_BTN; i++) begin
            settle[i]   = (sync_q2[i] != stable[i]) && (cnt[i] == CNT_LAST);
            rise[i]     = settle[i] && sync_q2[i];
            wr_hit[i]   = bus.ctrl_writeReg == ADDR_W'(BTN_BASE + i);
            rd_hit_a[i] = bus.ctrl_readRegA == ADDR_W'(BTN_BASE + i);
            rd_hit_b[i] = bus.ctrl_readRegB == ADDR_W'(BTN_BASE + i);
        end
        wr_any     = bus.ctrl_writeEnable && (bus.ctrl_writeReg != '0);
        // in status mode a button-register write only acknowledges the press
        wr_store   = wr_any && !(!io_mode && (|wr_hit));
        sticky_clr = {N_BTN{wr_any && !io_mode}} & wr_hit;
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                regs[j] <= '0;
            end
        end else if (wr_store) begin
            regs[bus.ctrl_writeReg] <= bus.data_writeReg;
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset_n) begin
            sync_q1   <= '0;
            sync_q2   <= '0;
            stable    <= '0;
            sticky    <= '0;
            btn_event <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync_q1   <= btn_in;
            sync_q2   <= sync_q1;
            btn_event <= rise;
            sticky    <= (sticky & ~sticky_clr) | rise;
            for (int i = 0; i < N_BTN; i++) begin
                if (sync_q2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (settle[i]) begin
                    stable[i] <= sync_q2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        rd_a = regs[bus.ctrl_readRegA];
        rd_b = regs[bus.ctrl_readRegB];
`ifdef IO_REGFILE_BYPASS_EN
        if (bus.ctrl_writeEnable &&
            bus.ctrl_writeReg == bus.ctrl_readRegA) begin
            rd_a = bus.data_writeReg;
        end
        if (bus.ctrl_writeEnable &&
            bus.ctrl_writeReg == bus.ctrl_readRegB) begin
            rd_b = bus.data_writeReg;
        end
`else
`endif
        // status words take priority and are never forwarded
        if (!io_mode) begin
            for (int i = 0; i < N_BTN; i++) begin
                if (rd_hit_a[i]) rd_a = DATA_W'({sticky[i], stable[i]});
                if (rd_hit_b[i]) rd_b = DATA_W'({sticky[i], stable[i]});
            end
        end
        if (bus.ctrl_readRegA == '0) rd_a = '0;
        if (bus.ctrl_readRegB == '0) rd_b = '0;
    end

    assign bus.data_readRegA = rd_a;
    assign bus.data_readRegB = rd_b;

    for (genvar g = 0; g < N_OUT; g++) begin : g_out
        localparam logic [ADDR_W-1:0] OA = ADDR_W'(OUT_BASE + g);
        assign io_out[g*DATA_W +: DATA_W] = regs[OA];
    end
endmodule
